// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C burst arbiter.
// Build with I2C_ARB_TIMEOUT_EN defined to include the XFER watchdog.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_DONE,
    S_ABORT
  } state_e;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  localparam int BURST_LEN_DEF = 32;
  localparam int TIMEOUT_DEF   = 4096;

endpackage

// File: rtl/i2c_ack_sync.sv
// Brings the engine acknowledge into clk and turns each rise into
// a single-cycle pulse.
module i2c_ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ack_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ack_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/i2c_burst_arbiter.sv
// Round-robin arbiter for two clients sharing one I2C byte engine.
// I2C_ARB_TIMEOUT_EN adds a watchdog that aborts a stalled burst.
module i2c_burst_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = 6,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] dir,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic       wr_pop,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       eng_wr,
  output logic       eng_rd,
  output logic [7:0] eng_wdata,
  input  logic [7:0] eng_rdata,
  input  logic       eng_ack
);

  state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] rdat_q, rdat_d;
  logic pop_q, pop_d;
  logic rdv_q, rdv_d;
  logic ack_p, wd_exp, win;
  logic [7:0] wsel;
  logic [1:0] own_oh;

  i2c_ack_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ack_i   (eng_ack),
    .pulse_o (ack_p)
  );

  // Under contention the requester not served last wins.
  assign win    = (&req) ? ~last_q : req[1];
  assign wsel   = owner_q ? wdata1 : wdata0;
  assign own_oh = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    pop_d   = 1'b0;
    rdv_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = win;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        dir_d = dir[owner_q];
        cnt_d = '0;
        if (dir[owner_q] == DIR_WR) wdat_d = wsel;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (pop_q) wdat_d = wsel;
        if (cnt_q == CNT_W'(BURST_LEN)) begin
          state_d = S_DONE;
        end else if (ack_p) begin
          cnt_d = cnt_q + 1'b1;
          if (dir_q == DIR_RD) begin
            rdat_d = eng_rdata;
            rdv_d  = 1'b1;
          end else begin
            pop_d = 1'b1;
          end
        end else if (wd_exp) begin
          state_d = S_ABORT;
        end
      end
      S_DONE, S_ABORT: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      dir_q   <= DIR_WR;
      cnt_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      pop_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      pop_q   <= pop_d;
      rdv_q   <= rdv_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts idle cycles in XFER; every ack pulse restarts it.
  always_comb begin
    wd_d = '0;
    if (state_q == S_XFER && !ack_p) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign wd_exp = (state_q == S_XFER) &&
                  (wd_q == WD_W'(TIMEOUT - 1));
  assign err    = (state_q == S_ABORT) ? own_oh : 2'b00;
`else
  assign wd_exp = 1'b0;
  assign err    = 2'b00;
`endif

  assign gnt       = (state_q == S_XFER) ? own_oh : 2'b00;
  assign eng_wr    = (state_q == S_XFER) && (dir_q == DIR_WR);
  assign eng_rd    = (state_q == S_XFER) && (dir_q == DIR_RD);
  assign done      = (state_q == S_DONE) ? own_oh : 2'b00;
  assign wr_pop    = pop_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdat_q;
  assign eng_wdata = wdat_q;

endmodule

// File: tb/tb_i2c_burst_arbiter.sv
// Randomized bench for i2c_burst_arbiter with engine/client models.
// Define I2C_ARB_TIMEOUT_EN to exercise the watchdog abort path.
`timescale 1ns/1ps
module tb_i2c_burst_arbiter;

  localparam int BL = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic [7:0] wdata0, wdata1;
  logic [7:0] eng_rdata = 8'h00;
  logic       eng_ack = 1'b0;
  logic [1:0] gnt, done, err;
  logic       wr_pop, rd_valid, eng_wr, eng_rd;
  logic [7:0] rd_data, eng_wdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop_cyc = 0;
  int last_end_cyc = 0;
  logic [7:0] wbase [2];
  logic [7:0] wptr [2];
  logic [7:0] rbase = 8'h00;
  logic [7:0] cap0[$], cap1[$], rdq[$];
  logic [1:0] done_log[$], err_log[$], gnt_log[$];
  logic [1:0] prev_gnt = 2'b00;
  int e_ph = 0;
  int e_t = 0;
  int acks_left = 1 << 30;
  logic [7:0] e_k = 8'h00;
  bit eng_auto = 1'b1;
  logic lastm = 1'b1;

  assign wdata0 = wbase[0] + wptr[0];
  assign wdata1 = wbase[1] + wptr[1];

  always #5 clk = ~clk;

  i2c_burst_arbiter #(
    .BURST_LEN (BL),
    .CNT_W     (6),
    .TIMEOUT   (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dir       (dir),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .wr_pop    (wr_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .eng_wr    (eng_wr),
    .eng_rd    (eng_rd),
    .eng_wdata (eng_wdata),
    .eng_rdata (eng_rdata),
    .eng_ack   (eng_ack)
  );

  // Engine: random gap, ack held 3..5 cycles, then at least 2 low.
  always @(negedge clk) begin
    if (!rst_n) begin
      e_ph = 0; e_t = 0; eng_ack = 1'b0;
    end else if (!eng_auto) begin
      e_ph = 0; e_t = 0;
    end else begin
      case (e_ph)
        0: if ((eng_wr || eng_rd) && acks_left > 0) begin
          if (e_t > 0) e_t--;
          else begin
            if (eng_wr) begin
              if (gnt[1]) cap1.push_back(eng_wdata);
              else        cap0.push_back(eng_wdata);
            end
            eng_rdata = rbase + e_k;
            e_k++;
            eng_ack = 1'b1;
            acks_left--;
            e_t = $urandom_range(3, 5);
            e_ph = 1;
          end
        end
        1: begin
          e_t--;
          if (e_t == 0) begin eng_ack = 1'b0; e_t = 2; e_ph = 2; end
        end
        default: begin
          e_t--;
          if (e_t == 0) begin e_ph = 0; e_t = $urandom_range(0, 3); end
        end
      endcase
    end
  end

  // Client side: each wr_pop advances the owner's write byte.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (wr_pop) begin
        pops++;
        last_pop_cyc = cyc;
        if (gnt[1]) wptr[1]++;
        else        wptr[0]++;
      end
      if (rd_valid) begin rdq.push_back(rd_data); last_pop_cyc = cyc; end
      if (done != 2'b00) begin done_log.push_back(done); last_end_cyc = cyc; end
      if (err != 2'b00) begin err_log.push_back(err); last_end_cyc = cyc; end
      if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(gnt);
      prev_gnt = gnt;
    end else begin
      prev_gnt = 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {gnt, wr_pop, rd_data, rd_valid, done, err,
              eng_wr, eng_rd, eng_wdata}, 32'h0);
  endtask

  task automatic clear_logs();
    pops = 0; e_k = 8'h00;
    wptr[0] = 8'h00; wptr[1] = 8'h00;
    cap0.delete(); cap1.delete(); rdq.delete();
    done_log.delete(); err_log.delete(); gnt_log.delete();
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    while (gnt == 2'b00 && lat < 20) begin tick(); lat++; end
  endtask

  task automatic wait_end(input int bound);
    int n0, c;
    n0 = done_log.size() + err_log.size();
    c = 0;
    while (done_log.size() + err_log.size() == n0 && c < bound) begin
      tick(); c++;
    end
    chk("end_seen", 32'(done_log.size() + err_log.size() != n0), 1);
  endtask

  task automatic check_burst(input int o, input bit rd, input logic [7:0] base);
    if (rd) begin
      chk("rd_cnt", rdq.size(), BL);
      foreach (rdq[k]) chk("rd_data", rdq[k], 8'(base + k));
    end else begin
      chk("pop_cnt", pops, BL);
      chk("cap_cnt", (o == 1) ? cap1.size() : cap0.size(), BL);
      if (o == 1) foreach (cap1[k]) chk("wr_byte1", cap1[k], 8'(base + k));
      else        foreach (cap0[k]) chk("wr_byte0", cap0[k], 8'(base + k));
    end
  endtask

  // Model: single requester wins outright, contention goes to !last.
  task automatic one_burst(input logic [1:0] r, input logic [1:0] d);
    int lat, o;
    bit rd;
    clear_logs();
    wbase[0] = 8'($urandom); wbase[1] = 8'($urandom); rbase = 8'($urandom);
    o = (r == 2'b11) ? (lastm ? 0 : 1) : (r[1] ? 1 : 0);
    rd = d[o];
    dir = d; req = r;
    wait_gnt(lat);
    chk("gnt_lat", lat, 2);
    chk("gnt_own", gnt, (o == 1) ? 2 : 1);
    chk("enable", {eng_rd, eng_wr}, rd ? 2 : 1);
    req = 2'b00; dir = ~d;
    wait_end(2000);
    chk("done_own", done, (o == 1) ? 2 : 1);
    chk("done_lat", last_end_cyc - last_pop_cyc, 1);
    tick();
    chk("idle_out", {gnt, eng_rd, eng_wr, done}, 0);
    chk("done_once", done_log.size(), 1);
    check_burst(o, rd, rd ? rbase : wbase[o]);
    lastm = o[0];
  endtask

  initial begin
    int lat, o, c;
    int exp_own [4];
    wbase[0] = 8'h00; wbase[1] = 8'h00;
    wptr[0] = 8'h00;  wptr[1] = 8'h00;
    repeat (3) tick();
    chk_zero("reset_outs");
    rst_n = 1'b1;
    tick();
    chk_zero("post_reset_idle");

    // Contention straight out of reset, both held for four bursts.
    clear_logs();
    wbase[0] = 8'($urandom); wbase[1] = 8'($urandom);
    dir = 2'b00; req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      o = lastm ? 0 : 1;
      exp_own[j] = o;
      wait_end(2000);
      chk("rr_done", done, (o == 1) ? 2 : 1);
      lastm = o[0];
    end
    req = 2'b00;
    repeat (4) tick();
    chk("rr_idle", gnt, 0);
    chk("rr_gnt_cnt", gnt_log.size(), 4);
    foreach (gnt_log[j]) chk("rr_gnt", gnt_log[j], (exp_own[j] == 1) ? 2 : 1);
    chk("rr_cap0_cnt", cap0.size(), 2 * BL);
    chk("rr_cap1_cnt", cap1.size(), 2 * BL);
    foreach (cap0[k]) chk("rr_wr0", cap0[k], 8'(wbase[0] + k));
    foreach (cap1[k]) chk("rr_wr1", cap1[k], 8'(wbase[1] + k));

    // Directed write from client 0 and read to client 1.
    one_burst(2'b01, 2'b00);
    one_burst(2'b10, 2'b10);

    // Ack held 5 cycles counts once, 3 cycles after its rise.
    clear_logs();
    wbase[0] = 8'($urandom);
    eng_auto = 1'b0; dir = 2'b00; req = 2'b01;
    wait_gnt(lat);
    chk("sync_gnt_lat", lat, 2);
    tick(); tick();
    eng_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sync_pop", wr_pop, 32'(k == 3));
    end
    eng_ack = 1'b0;
    repeat (4) tick();
    chk("sync_once", pops, 1);
    eng_auto = 1'b1; req = 2'b00;
    wait_end(2000);
    chk("sync_total", pops, BL);
    chk("sync_done", done, 1);
    lastm = 1'b0;
    tick();

    // Reset in the middle of a write burst.
    clear_logs();
    wbase[0] = 8'($urandom);
    dir = 2'b00; req = 2'b01;
    c = 0;
    while (pops < 10 && c < 1000) begin tick(); c++; end
    chk("mid_pops", pops, 10);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst_async");
    tick();
    chk_zero("mid_rst_next");
    chk("mid_no_done", done_log.size(), 0);
    rst_n = 1'b1;
    lastm = 1'b1;
    one_burst(2'b01, 2'b00);

    // Random request and direction patterns.
    for (int j = 0; j < 6; j++) begin
      logic [1:0] rr, dd;
      rr = 2'($urandom_range(1, 3));
      dd = 2'($urandom_range(0, 3));
      one_burst(rr, dd);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Engine stops after 5 bytes; the other client is served next.
    clear_logs();
    wbase[0] = 8'($urandom); wbase[1] = 8'($urandom);
    acks_left = 5; dir = 2'b00; req = 2'b11;
    o = lastm ? 0 : 1;
    wait_end(1000);
    chk("to_err", err, (o == 1) ? 2 : 1);
    chk("to_lat", last_end_cyc - last_pop_cyc, 100);
    chk("to_pops", pops, 5);
    chk("to_no_done", done_log.size(), 0);
    acks_left = 1 << 30;
    wait_gnt(lat);
    chk("to_next_gnt", gnt, (o == 1) ? 1 : 2);
    req = 2'b00;
    wait_end(2000);
    chk("to_next_done", done, (o == 1) ? 1 : 2);
    lastm = ~o[0];
`else
    chk("err_never", err_log.size(), 0);
`endif

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/i2c_burst_arbiter.md
# i2c_burst_arbiter

Arbitrates two client requesters onto the single I2C byte engine and sequences each granted request as a fixed-length burst of byte transfers. Drives the engine's write/read enables and write-data byte, counts engine acknowledges, and returns read bytes and completion status to the owning requester. Sits between the system-side clients and the I2C byte engine, in the `clk` domain. The engine runs on the divided SCL clock.

## Interface
- `BURST_LEN`, 32: bytes per granted burst; must be at least 1.
- `CNT_W`, 6: width of the byte counter; must satisfy 2^CNT_W > BURST_LEN.
- `TIMEOUT`, 4096: `clk` cycles allowed between acks; used only when the timeout feature is compiled in.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 2: per-requester burst request; level-sensitive.
- `dir` in 2: per-requester direction; 0 = write, 1 = read. Sampled at grant.
- `wdata0`, `wdata1` in 8 each: next write byte from requester 0 and requester 1.
- `gnt` out 2: one-hot owner of the engine for the current burst.
- `wr_pop` out 1: one-cycle pulse; the owner's current write byte has been accepted.
- `rd_data` out 8: last byte read from the engine.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is new.
- `done` out 2: one-cycle pulse to the owner when its burst completes.
- `err` out 2: one-cycle pulse to the owner when its burst is aborted.
- `eng_wr`, `eng_rd` out 1 each: engine write and read enables.
- `eng_wdata` out 8: byte presented to the engine.
- `eng_rdata` in 8: byte returned by the engine.
- `eng_ack` in 1: engine byte acknowledge; asynchronous to `clk`, level stays high for at least 3 `clk` cycles.

## Operation
- States are IDLE, GRANT, XFER, DONE and ABORT.
- **IDLE**
  - If any `req` bit is set, pick a winner by round-robin and go to GRANT.
  - The winner is the requester not served last. The last-served pointer resets to 1, so requester 0 wins the first contention.
- **GRANT** (1 cycle)
  - Set `gnt`, latch `dir` of the winner, clear the byte counter.
  - For a write, load `eng_wdata` from the winner's `wdata`.
- **XFER**
  - `eng_wr` (write) or `eng_rd` (read) is held high for the entire state.
  - Each synchronized ack pulse increments the counter. Then:
    - Write: pulse `wr_pop`, reload `eng_wdata` from `wdata` on the next cycle.
    - Read: `rd_data` <= `eng_rdata`, pulse `rd_valid`.
  - When the counter reaches BURST_LEN, go to DONE.
- **DONE** (1 cycle)
  - Pulse `done[owner]`, drop the engine enables and `gnt`, update the pointer, return to IDLE.
- Dropping `req` mid-burst has no effect; the burst always completes or aborts.
- A requester holding `req` continuously is re-arbitrated after DONE. A pending other requester is served first.
- Counter arithmetic is unsigned CNT_W bits and does not wrap within a burst.

## Timing
- Reset value of every output is 0. Reset mid-burst clears all outputs and returns to IDLE immediately. There is no partial-burst `done`.
- `eng_ack` passes through a 2-flop synchronizer and a rising-edge detector. The resulting pulse arrives 3 `clk` cycles after `eng_ack` rises.
- Latencies:
  - `req` high in IDLE -> `gnt` high 2 cycles later.
  - Ack pulse -> `wr_pop`, `rd_valid` and the counter update in the same cycle.
  - Final ack pulse -> `done` 1 cycle later.
- `rd_data` holds its value until the next read ack.
- A simultaneous ack pulse and reset: reset wins.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A watchdog counts `clk` cycles in XFER and restarts on each ack pulse.
  - At TIMEOUT the block goes to ABORT (1 cycle): pulse `err[owner]`, drop the enables and `gnt`, update the pointer, return to IDLE.
- `I2C_ARB_TIMEOUT_EN` undefined: no watchdog, XFER waits indefinitely, `err` is tied to 0.

## Structure
- Package `i2c_arb_pkg` holds:
  - the state enum;
  - `DIR_WR`/`DIR_RD` constants;
  - the default values for BURST_LEN and TIMEOUT.
- Sub-module `i2c_ack_sync`: 2-flop synchronizer plus rising-edge pulse generator for `eng_ack`.

## Test plan
- Write, single requester: `req=01`, `dir=00`, `wdata0` increments 0..31 on each `wr_pop`, engine acks 32 times -> `eng_wdata` sequence 0..31, 32 `wr_pop` pulses, `done=01` once, `eng_wr` low afterwards.
- Read: `req=10`, `dir=10`, engine returns 0..31 -> 32 `rd_valid` pulses with `rd_data` 0..31, then `done=10`.
- Contention: `req=11` asserted together out of reset -> requester 0 is served first. With both held high, grants alternate 0,1,0,1.
- Reset mid-burst: assert `rst_n` low after ack 10 -> all outputs are 0 next cycle, no `done`. After release with `req=01`, a full 32-byte burst completes.
- Ack synchronization: `eng_ack` held high for 5 cycles -> exactly one counter increment, 3 cycles after the rise.
- With `I2C_ARB_TIMEOUT_EN` and TIMEOUT=100: acks stop after byte 5 -> `err[owner]` pulses 100 cycles after the last ack pulse, the block is back in IDLE, and the pending other requester is granted next.
